// File: rtl/systolic_pkg.sv
// Shared state encoding and default array sizing for the systolic result drain.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } drain_state_t;

    localparam int DEF_W                = 4;
    localparam int DEF_DATA_WIDTH_ACCUM = 32;

endpackage

// File: rtl/systolic_drain_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is always visible on o_rdata.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    // A write into a full FIFO is still legal when the head leaves on the same edge.
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_rdata  = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/systolic_drain.sv
// De-skews systolic array result lanes, buffers whole result vectors and
// streams them downstream with a valid/ready handshake.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int W                = DEF_W,
    parameter int DATA_WIDTH_ACCUM = DEF_DATA_WIDTH_ACCUM,
    parameter int FIFO_DEPTH       = 8,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic signed [W-1:0][DATA_WIDTH_ACCUM-1:0] sys_data_out,
    input  logic [W-1:0]                             sys_valid_out,
    input  logic [W-1:0]                             cfg_enable_cols,
    input  logic [CNT_WIDTH-1:0]                     cfg_n,
    input  logic                                     start,
    output logic signed [W-1:0][DATA_WIDTH_ACCUM-1:0] out_data,
    output logic [W-1:0]                             out_lane_valid,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     overflow,
    output logic                                     skew_err
);

    localparam int DW = DATA_WIDTH_ACCUM;
    localparam int FW = W * DW + W;

    drain_state_t           r_state;
    logic [W-1:0]           r_mask;
    logic [CNT_WIDTH-1:0]   r_n;
    logic [CNT_WIDTH-1:0]   r_pushCnt;
    logic [CNT_WIDTH-1:0]   r_popCnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;
    logic                   r_skewErr;

    logic [W-1:0][DW-1:0]   w_alignData;
    logic [W-1:0]           w_alignValid;
    logic [W-1:0][DW-1:0]   w_pushData;
    logic [W-1:0]           w_laneValid;
    logic                   w_anyValid;
    logic                   w_skew;
    logic                   w_pushReq;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [FW-1:0]          w_rdata;
    logic [CNT_WIDTH-1:0]   w_pushNext;
    logic [CNT_WIDTH-1:0]   w_popNext;

    // Lane i gets W-i registers so every lane of one column lands on the same edge.
    for (genvar i = 0; i < W; i++) begin : g_lane
        logic [DW-1:0] r_data  [W-i];
        logic          r_valid [W-i];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int s = 0; s < W - i; s++) begin
                    r_data[s]  <= '0;
                    r_valid[s] <= 1'b0;
                end
            end else begin
                r_data[0]  <= sys_data_out[i];
                r_valid[0] <= sys_valid_out[i];
                for (int s = 1; s < W - i; s++) begin
                    r_data[s]  <= r_data[s-1];
                    r_valid[s] <= r_valid[s-1];
                end
            end
        end

        assign w_alignData[i]  = r_data[W-i-1];
        assign w_alignValid[i] = r_valid[W-i-1];
    end

    assign w_laneValid = w_alignValid & r_mask;
    assign w_anyValid  = |w_laneValid;
    assign w_skew      = w_anyValid && (w_laneValid != r_mask);
    assign w_pushReq   = (r_state == COLLECT) && w_anyValid;
    assign w_pop       = out_valid && out_ready;
    assign w_drop      = w_pushReq && w_full && !w_pop;
    assign w_pushNext  = r_pushCnt + CNT_WIDTH'(1);
    assign w_popNext   = r_popCnt + CNT_WIDTH'(1);

    always_comb begin
        w_pushData = '0;
        for (int i = 0; i < W; i++) begin
            if (r_mask[i]) w_pushData[i] = w_alignData[i];
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_pushReq),
        .i_wdata ({w_laneValid, w_pushData}),
        .i_pop   (out_ready),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid      = !w_empty;
    assign out_data       = out_valid ? w_rdata[W*DW-1:0] : '0;
    assign out_lane_valid = out_valid ? w_rdata[W*DW +: W] : '0;
    assign out_last       = out_valid && (w_popNext == r_n);
    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_overflow;
    assign skew_err       = r_skewErr;

    // Dropped vectors still advance the push count, so an overflowed run never completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_n        <= '0;
            r_pushCnt  <= '0;
            r_popCnt   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_skewErr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mask     <= cfg_enable_cols;
                        r_n        <= cfg_n;
                        r_pushCnt  <= '0;
                        r_popCnt   <= '0;
                        r_overflow <= 1'b0;
                        r_skewErr  <= 1'b0;
                        if (cfg_n == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= COLLECT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (w_pushReq) begin
                        r_pushCnt <= w_pushNext;
                        if (w_skew) r_skewErr <= 1'b1;
                        if (w_drop) r_overflow <= 1'b1;
                        if (w_pushNext == r_n) r_state <= DRAIN;
                    end
                    if (w_pop) r_popCnt <= w_popNext;
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_popCnt <= w_popNext;
                        if (w_popNext == r_n) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed, table-driven bench for systolic_drain with hand-computed expected vectors.
module tb_systolic_drain;

    localparam int W  = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic signed [W-1:0][DW-1:0] sys_data_out;
    logic [W-1:0]                sys_valid_out;
    logic [W-1:0]                cfg_enable_cols;
    logic [CW-1:0]               cfg_n;
    logic                        start;
    logic                        out_ready;
    logic signed [W-1:0][DW-1:0] out_data;
    logic [W-1:0]                out_lane_valid;
    logic                        out_valid;
    logic                        out_last;
    logic                        busy;
    logic                        done;
    logic                        overflow;
    logic                        skew_err;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0]        mask;
        logic [3:0]        valid;
        logic [3:0][31:0]  d;
        logic [3:0]        expLv;
        logic [3:0][31:0]  expD;
        logic              expSkew;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    systolic_drain #(
        .W                (W),
        .DATA_WIDTH_ACCUM (DW),
        .FIFO_DEPTH       (8),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sys_data_out    (sys_data_out),
        .sys_valid_out   (sys_valid_out),
        .cfg_enable_cols (cfg_enable_cols),
        .cfg_n           (cfg_n),
        .start           (start),
        .out_data        (out_data),
        .out_lane_valid  (out_lane_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .skew_err        (skew_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] v, input logic [W-1:0][DW-1:0] d);
        sys_valid_out = v;
        sys_data_out  = d;
    endtask

    function automatic logic [127:0] fullVec(input int k);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < W; i++) v[i*DW +: DW] = DW'(100 * k + i);
        return v;
    endfunction

    // Drives cycle c of a stream of `count` full vectors numbered from `base`, skewed by lane.
    task automatic driveSkewed(input int c, input int base, input int count);
        logic [W-1:0]         v;
        logic [W-1:0][DW-1:0] d;
        logic [127:0]         fv;
        v = '0;
        d = '0;
        for (int i = 0; i < W; i++) begin
            if (c - i >= 0 && c - i < count) begin
                v[i] = 1'b1;
                fv   = fullVec(base + c - i);
                d[i] = fv[i*DW +: DW];
            end
        end
        applyStimulus(v, d);
    endtask

    task automatic armCollection(input logic [W-1:0] mask, input logic [CW-1:0] n);
        cfg_enable_cols = mask;
        cfg_n           = n;
        start           = 1'b1;
        tick();
        start           = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " out_valid"}, out_valid, 0);
        checkOutput({tag, " out_lane_valid"}, out_lane_valid, 0);
        checkOutput({tag, " out_last"}, out_last, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " overflow"}, overflow, 0);
        checkOutput({tag, " skew_err"}, skew_err, 0);
        checkOutput({tag, " out_data"}, out_data, 0);
    endtask

    task automatic runOneVector(input vec_t t, input int idx);
        logic [W-1:0]         v;
        logic [W-1:0][DW-1:0] d;
        armCollection(t.mask, 1);
        for (int c = 0; c < W; c++) begin
            v = '0;
            d = '0;
            v[c] = t.valid[c];
            if (t.valid[c]) d[c] = t.d[c];
            applyStimulus(v, d);
            tick();
        end
        applyStimulus('0, '0);
        tick();
        tick();
        checkOutput($sformatf("vec%0d out_valid", idx), out_valid, 1);
        checkOutput($sformatf("vec%0d out_data", idx), out_data, t.expD);
        checkOutput($sformatf("vec%0d lane_valid", idx), out_lane_valid, t.expLv);
        checkOutput($sformatf("vec%0d out_last", idx), out_last, 1);
        checkOutput($sformatf("vec%0d skew_err", idx), skew_err, t.expSkew);
        checkOutput($sformatf("vec%0d busy", idx), busy, 1);
        out_ready = 1'b1;
        tick();
        checkOutput($sformatf("vec%0d done", idx), done, 1);
        checkOutput($sformatf("vec%0d busy after", idx), busy, 0);
        checkOutput($sformatf("vec%0d drained", idx), out_valid, 0);
        out_ready = 1'b0;
        tick();
        checkOutput($sformatf("vec%0d done pulse", idx), done, 0);
    endtask

    initial begin
        int idx;
        int doneCount;
        logic [W-1:0][DW-1:0] d;

        vecs[0] = '{4'b1111, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1},
                    4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0};
        vecs[1] = '{4'b0101, 4'b1111, {32'd40, 32'd30, 32'd20, 32'd10},
                    4'b0101, {32'd0, 32'd30, 32'd0, 32'd10}, 1'b0};
        vecs[2] = '{4'b1111, 4'b0110, {32'd0, 32'hFFFF_FFFB, 32'd7, 32'd0},
                    4'b0110, {32'd0, 32'hFFFF_FFFB, 32'd7, 32'd0}, 1'b1};
        vecs[3] = '{4'b1000, 4'b1000, {32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0},
                    4'b1000, {32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0}, 1'b0};
        vecs[4] = '{4'b0011, 4'b0111, {32'd0, 32'd99, 32'd88, 32'd77},
                    4'b0011, {32'd0, 32'd0, 32'd88, 32'd77}, 1'b0};
        vecs[5] = '{4'b1110, 4'b0010, {32'd0, 32'd0, 32'd5, 32'd0},
                    4'b0010, {32'd0, 32'd0, 32'd5, 32'd0}, 1'b1};

        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        cfg_enable_cols = '0;
        cfg_n = '0;
        applyStimulus('0, '0);
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) runOneVector(vecs[t], t);

        // Two-lane example: lane 1 trails lane 0 by one cycle.
        armCollection(4'b0011, 2);
        d = '0; d[0] = 32'd70;
        applyStimulus(4'b0001, d); tick();
        d = '0; d[0] = 32'd100; d[1] = 32'd150;
        applyStimulus(4'b0011, d); tick();
        d = '0; d[1] = 32'd220;
        applyStimulus(4'b0010, d); tick();
        applyStimulus('0, '0);
        for (int c = 0; c < 4; c++) tick();
        checkOutput("ex1 v0 data", out_data, {32'd0, 32'd0, 32'd150, 32'd70});
        checkOutput("ex1 v0 lane_valid", out_lane_valid, 4'b0011);
        checkOutput("ex1 v0 last", out_last, 0);
        out_ready = 1'b1;
        tick();
        checkOutput("ex1 v1 data", out_data, {32'd0, 32'd0, 32'd220, 32'd100});
        checkOutput("ex1 v1 last", out_last, 1);
        checkOutput("ex1 skew_err", skew_err, 0);
        tick();
        checkOutput("ex1 done", done, 1);
        checkOutput("ex1 busy", busy, 0);
        out_ready = 1'b0;
        tick();
        checkOutput("ex1 done pulse", done, 0);

        // Downstream stalls every other cycle; stalled data must not move.
        armCollection(4'b1111, 3);
        idx = 0;
        doneCount = 0;
        for (int c = 0; c < 30; c++) begin
            driveSkewed(c, 20, 3);
            out_ready = (c % 2 == 0);
            if (out_valid) begin
                checkOutput($sformatf("stall data %0d", idx), out_data, fullVec(20 + idx));
                checkOutput($sformatf("stall last %0d", idx), out_last, (idx == 2));
                if (out_ready) idx++;
            end
            if (done) doneCount++;
            tick();
        end
        out_ready = 1'b0;
        checkOutput("stall delivered", idx, 3);
        checkOutput("stall done count", doneCount, 1);
        checkOutput("stall busy", busy, 0);

        // Lane 1 arrives one cycle later than its skew slot.
        armCollection(4'b0011, 2);
        d = '0; d[0] = 32'd11;
        applyStimulus(4'b0001, d); tick();
        applyStimulus('0, '0); tick();
        d = '0; d[1] = 32'd22;
        applyStimulus(4'b0010, d); tick();
        applyStimulus('0, '0);
        for (int c = 0; c < 4; c++) tick();
        checkOutput("skew flag", skew_err, 1);
        checkOutput("skew v0 lane_valid", out_lane_valid, 4'b0001);
        checkOutput("skew v0 data", out_data, {32'd0, 32'd0, 32'd0, 32'd11});
        out_ready = 1'b1;
        tick();
        checkOutput("skew v1 lane_valid", out_lane_valid, 4'b0010);
        checkOutput("skew v1 data", out_data, {32'd0, 32'd0, 32'd22, 32'd0});
        checkOutput("skew v1 last", out_last, 1);
        tick();
        checkOutput("skew done", done, 1);
        out_ready = 1'b0;
        tick();

        armCollection(4'b1111, 0);
        checkOutput("n0 done", done, 1);
        checkOutput("n0 busy", busy, 0);
        tick();
        checkOutput("n0 done pulse", done, 0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("n0 out_valid %0d", c), out_valid, 0);
            tick();
        end

        // Ten vectors into an eight-deep buffer with the consumer stalled.
        armCollection(4'b1111, 10);
        for (int c = 0; c < 13; c++) begin
            driveSkewed(c, 0, 10);
            tick();
        end
        applyStimulus('0, '0);
        for (int c = 0; c < 3; c++) tick();
        checkOutput("ovf flag", overflow, 1);
        checkOutput("ovf busy", busy, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("ovf valid %0d", k), out_valid, 1);
            checkOutput($sformatf("ovf data %0d", k), out_data, fullVec(k));
            checkOutput($sformatf("ovf last %0d", k), out_last, 0);
            checkOutput($sformatf("ovf done %0d", k), done, 0);
            tick();
        end
        checkOutput("ovf empty", out_valid, 0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("ovf no done %0d", c), done, 0);
            checkOutput($sformatf("ovf stuck busy %0d", c), busy, 1);
            tick();
        end
        out_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("ovf reset busy", busy, 0);

        // Reset lands with two vectors buffered and two still in the delay lines.
        armCollection(4'b1111, 4);
        for (int c = 0; c < 6; c++) begin
            driveSkewed(c, 40, 4);
            tick();
        end
        checkOutput("mid pre-reset valid", out_valid, 1);
        rst = 1'b0;
        applyStimulus('0, '0);
        tick();
        checkAllZero("mid reset");
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("mid post valid %0d", c), out_valid, 0);
            checkOutput($sformatf("mid post done %0d", c), done, 0);
            tick();
        end
        runOneVector(vecs[0], 99);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning systolic array width (number of output lanes).
REQ-002 The block SHALL have parameter DATA_WIDTH_ACCUM, default 32, meaning width of each accumulator result.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning result vectors buffered (power of two).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, meaning width of the result-vector count.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 sys_data_out  input  W x DATA_WIDTH_ACCUM signed  skewed array results; lane i lags lane i-1 by one cycle.
REQ-008 sys_valid_out  input  W x 1  per-lane result valid.
REQ-009 cfg_enable_cols  input  W  active-lane mask (M mask), sampled on start.
REQ-010 cfg_n  input  CNT_WIDTH  number of result vectors expected, sampled on start.
REQ-011 start  input  1  one-cycle pulse that arms a collection.
REQ-012 out_data  output  W x DATA_WIDTH_ACCUM signed  de-skewed result vector (column j of E).
REQ-013 out_lane_valid  output  W  per-lane valid of out_data.
REQ-014 out_valid / out_ready  output / input  1 / 1  downstream handshake; transfer when both high.
REQ-015 out_last  output  1  marks the cfg_n-th vector.
REQ-016 busy, done, overflow, skew_err  output  1 each  status: armed, one-cycle completion pulse, sticky drop flag, sticky misalignment flag.

Function
REQ-017 Lane i SHALL pass through a delay line of W-i registers, so samples of one result column reach the aligned stage on the same edge.
REQ-018 A lane-0 sample captured at edge E SHALL be written to the FIFO at edge E+W and be visible on out_data with out_valid=1 in the cycle after that edge.
REQ-019 A push SHALL occur when any lane enabled in the latched mask is valid at the aligned stage; out_lane_valid = aligned valids AND latched mask; disabled lanes SHALL output zero.
REQ-020 If enabled lanes disagree on aligned valid in one cycle, skew_err SHALL set and the vector SHALL still be pushed.
REQ-021 FSM states: IDLE, COLLECT, DRAIN. IDLE->COLLECT on start (latch cfg_n, cfg_enable_cols, clear overflow/skew_err, busy=1); COLLECT->DRAIN when pushed count reaches cfg_n; DRAIN->IDLE when the cfg_n-th vector is popped, with done=1 for exactly that following cycle.
REQ-022 start with cfg_n=0 SHALL skip COLLECT: done pulses next cycle, no vectors output.
REQ-023 start while busy SHALL be ignored; aligned vectors in IDLE or DRAIN SHALL be dropped without setting any flag.
REQ-024 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Push when FIFO full SHALL drop the vector and set overflow (sticky), unless a pop occurs on the same edge, in which case both complete; the dropped vector still counts toward cfg_n.
REQ-026 out_last SHALL be high only with the vector whose pop index equals cfg_n.

Reset
REQ-027 While rst=0 on an edge: FSM=IDLE, FIFO empty, delay lines cleared, counters zero; out_valid, out_lane_valid, out_last, busy, done, overflow, skew_err = 0; out_data = 0.
REQ-028 Reset mid-collection SHALL discard all in-flight and buffered results; no done pulse is generated.

Structure
REQ-029 The drain_state_t enum and default W/DATA_WIDTH_ACCUM constants SHALL live in shared package systolic_pkg.
REQ-030 Buffering SHALL use one sub-module, sync_fifo (first-word-fall-through, full/empty flags).

Verification
REQ-031 cfg_enable_cols=4'b0011, cfg_n=2; lane0 70 then 100, lane1 150 then 220 one cycle later -> {70,150} last=0, {100,220} last=1, out_lane_valid=0011, done pulse, busy=0.
REQ-032 cfg_n=10, 10 consecutive full vectors, out_ready=0 for 12 cycles -> overflow=1, first 8 vectors delivered in order, done after 8th pop... not asserted until count 10 popped is impossible, so bench checks done never fires and busy stays 1 until reset.
REQ-033 cfg_n=3, out_ready toggling 1/0 each cycle -> all 3 vectors delivered unchanged while stalled, out_last on 3rd only.
REQ-034 Lane1 valid one cycle late relative to required skew -> skew_err=1, two partial vectors with out_lane_valid 0001 and 0010.
REQ-035 rst=0 asserted after 2 of 4 vectors pushed -> all outputs 0, next start with cfg_n=1 collects normally.
REQ-036 start with cfg_n=0 -> done=1 one cycle later, out_valid never asserted.
